// File: rtl/fpu_mul_seq.sv
// fpu_mul_seq: sequential IEEE-754 multiplier, RNE rounding, exception flags.
// Define FPU_MUL_SUBNORMAL_EN for gradual underflow; default build flushes to zero.
module fpu_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags,
    output logic                 done,
    output logic                 busy
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;
    localparam int P  = 2 * M;
    localparam int EW = EXP_W + $clog2(M) + 2;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, UNPACK, MULTIPLY, NORMALIZE, ROUND, DONE
    } state_t;

    typedef struct packed {
        logic                 zero;
        logic                 inf;
        logic                 nan;
        logic                 snan;
        logic [M-1:0]         man;
        logic signed [EW-1:0] exp;
    } opnd_t;

`ifdef FPU_MUL_SUBNORMAL_EN
    function automatic logic [EW-1:0] clz(input logic [M-1:0] m);
        logic [EW-1:0] n;
        n = EW'(M);
        for (int i = 0; i < M; i++)
            if (m[i]) n = EW'(M - 1 - i);
        return n;
    endfunction
`endif

    function automatic opnd_t classify(input logic [W-1:0] x);
        opnd_t o;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        logic e_max, e_min, f_nz;
`ifdef FPU_MUL_SUBNORMAL_EN
        logic [EW-1:0] lz;
`endif
        e     = x[W-2:MAN_W];
        f     = x[MAN_W-1:0];
        e_max = &e;
        e_min = ~|e;
        f_nz  = |f;
        o.nan  = e_max & f_nz;
        o.snan = e_max & f_nz & ~f[MAN_W-1];
        o.inf  = e_max & ~f_nz;
        o.man  = {~e_min, f};
        o.exp  = EW'(e);
`ifdef FPU_MUL_SUBNORMAL_EN
        o.zero = e_min & ~f_nz;
        // single-cycle pre-normalization: leading one moved to hidden position
        if (e_min && f_nz) begin
            lz    = clz(o.man);
            o.man = o.man << lz;
            o.exp = EW'(1) - lz;
        end
`else
        o.zero = e_min;
`endif
        return o;
    endfunction

    state_t state, state_nx;

    logic [W-1:0]         a_r, b_r;
    logic                 sign_r;
    opnd_t                oa_r, ob_r;
    logic [P-1:0]         prod_r;
    logic signed [EW-1:0] pexp_r;
    logic [MAN_W-1:0]     frac_r;
    logic                 guard_r, sticky_r, tiny_r;
    logic signed [EW-1:0] nexp_r;
    logic [W-1:0]         res_r;
    logic [3:0]           flg_r;

    logic [P-2:0]         pf;
    logic signed [EW-1:0] en;
    logic                 lost, tiny;
`ifdef FPU_MUL_SUBNORMAL_EN
    logic [EW-1:0]        sh;
    logic [P-1:0]         hv;
`endif

    logic                  inc, inexact;
    logic [EW+MAN_W-1:0]   rv;
    logic signed [EW-1:0]  rexp;
    logic [W-1:0]          res_c;
    logic [3:0]            flg_c;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (start) state_nx = UNPACK;
            UNPACK:    state_nx = MULTIPLY;
            MULTIPLY:  state_nx = NORMALIZE;
            NORMALIZE: state_nx = ROUND;
            ROUND:     state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        pf   = prod_r[P-1] ? prod_r[P-2:0] : {prod_r[P-3:0], 1'b0};
        en   = prod_r[P-1] ? pexp_r + EW'(1) : pexp_r;
        tiny = en[EW-1] | (en == '0);
        lost = 1'b0;
`ifdef FPU_MUL_SUBNORMAL_EN
        sh = '0;
        hv = {1'b1, pf};
        // denormalize: hidden bit shifts into the fraction, exponent field 0
        if (tiny) begin
            sh   = EW'(1) - en;
            lost = |(hv & ~({P{1'b1}} << sh));
            pf   = (P-1)'(hv >> sh);
            en   = '0;
        end
`endif
    end

    always_comb begin
        inc     = guard_r & (sticky_r | frac_r[0]);
        // carry out of the fraction lands in the exponent field
        rv      = {nexp_r, frac_r} + {{(EW+MAN_W-1){1'b0}}, inc};
        rexp    = signed'(rv[EW+MAN_W-1:MAN_W]);
        inexact = guard_r | sticky_r;
        res_c   = {sign_r, rv[EXP_W+MAN_W-1:0]};
        flg_c   = {2'b00, tiny_r & inexact, inexact};
        if (oa_r.nan || ob_r.nan) begin
            res_c = QNAN;
            flg_c = {oa_r.snan | ob_r.snan, 3'b000};
        end else if ((oa_r.inf && ob_r.zero) || (oa_r.zero && ob_r.inf)) begin
            res_c = QNAN;
            flg_c = 4'b1000;
        end else if (oa_r.inf || ob_r.inf) begin
            res_c = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_c = 4'b0000;
        end else if (oa_r.zero || ob_r.zero) begin
            res_c = {sign_r, {(W-1){1'b0}}};
            flg_c = 4'b0000;
        end else if (rexp >= EMAX) begin
            res_c = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_c = 4'b0101;
        end
`ifndef FPU_MUL_SUBNORMAL_EN
        else if (tiny_r) begin
            res_c = {sign_r, {(W-1){1'b0}}};
            flg_c = 4'b0011;
        end
`endif
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start) begin
                a_r <= a;
                b_r <= b;
            end
            UNPACK: begin
                sign_r <= a_r[W-1] ^ b_r[W-1];
                oa_r   <= classify(a_r);
                ob_r   <= classify(b_r);
            end
            MULTIPLY: begin
                prod_r <= P'(oa_r.man) * P'(ob_r.man);
                pexp_r <= oa_r.exp + ob_r.exp - BIAS;
            end
            NORMALIZE: begin
                frac_r   <= pf[P-2 -: MAN_W];
                guard_r  <= pf[M-1];
                sticky_r <= (|pf[M-2:0]) | lost;
                nexp_r   <= en;
                tiny_r   <= tiny;
            end
            ROUND: begin
                res_r <= res_c;
                flg_r <= flg_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            busy <= (state == UNPACK) || (state == MULTIPLY) ||
                    (state == NORMALIZE) || (state == ROUND);
            done <= (state == DONE);
            if (state == DONE) begin
                result <= res_r;
                flags  <= flg_r;
            end
        end
    end
endmodule

// File: tb/tb_fpu_mul_seq.sv
// tb_fpu_mul_seq: directed checks of fpu_mul_seq in binary32 and binary16.
// Expected values are hand-computed; FPU_MUL_SUBNORMAL_EN selects tiny-result vectors.
module tb_fpu_mul_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b, result;
    logic [3:0]  flags;
    logic        done, busy;
    logic        start_h;
    logic [15:0] a_h, b_h, result_h;
    logic [3:0]  flags_h;
    logic        done_h, busy_h;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    always #5 clk = ~clk;

    fpu_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .result(result), .flags(flags), .done(done), .busy(busy)
    );

    fpu_mul_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .start(start_h), .a(a_h), .b(b_h),
        .result(result_h), .flags(flags_h), .done(done_h), .busy(busy_h)
    );

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic [3:0] f,
                          output int lat, output bit busy_ok,
                          output bit pulse_ok);
        int n;
        n = 0;
        lat = -1;
        busy_ok = 1'b1;
        pulse_ok = 1'b1;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        while (lat < 0 && n < 20) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            a = ~x;
            b = x ^ y;
            if (busy !== (n >= 2 && n <= 5)) busy_ok = 1'b0;
            if (done === 1'b1) lat = n - 1;
        end
        r = result;
        f = flags;
        @(negedge clk);
        if (done !== 1'b0) pulse_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        start_h = 1'b0;
        a = '0; b = '0; a_h = '0; b_h = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: got %h, expected 00000000", result);
        end
        n_checks++;
        if (flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 0000", flags);
        end
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got done=%b busy=%b, expected 0 0", done, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        vec_t v[$];
        logic [31:0] r;
        logic [3:0] f;
        int lat;
        bit bok, pok;
        v.push_back('{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000});
        v.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001});
        v.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000});
        v.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101});
        v.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000});
        v.push_back('{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000});
        v.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000});
        v.push_back('{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000});
        v.push_back('{32'h00000000, 32'hC0400000, 32'h80000000, 4'b0000});
`ifdef FPU_MUL_SUBNORMAL_EN
        v.push_back('{32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000});
        v.push_back('{32'h00400000, 32'h3F800000, 32'h00400000, 4'b0000});
`else
        v.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011});
        v.push_back('{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000});
`endif
        v.push_back('{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001});
        v.push_back('{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001});
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, r, f, lat, bok, pok);
            n_checks++;
            if (lat !== 5) begin
                n_fail++;
                $display("FAIL latency[%0d]: got %0d, expected 5", i, lat);
            end
            n_checks++;
            if (r !== v[i].r) begin
                n_fail++;
                $display("FAIL result[%0d] %h*%h: got %h, expected %h",
                         i, v[i].a, v[i].b, r, v[i].r);
            end
            n_checks++;
            if (f !== v[i].f) begin
                n_fail++;
                $display("FAIL flags[%0d] %h*%h: got %b, expected %b",
                         i, v[i].a, v[i].b, f, v[i].f);
            end
            n_checks++;
            if (!bok || !pok) begin
                n_fail++;
                $display("FAIL handshake[%0d]: busy_ok=%0d pulse_ok=%0d, expected 1 1",
                         i, bok, pok);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        logic [31:0] r;
        logic [3:0] f;
        int lat;
        bit bok, pok;
        @(negedge clk);
        a = 32'h40400000;
        b = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got busy=%b done=%b, expected 0 0", busy, done);
        end
        n_checks++;
        if (result !== 32'h0 || flags !== 4'b0) begin
            n_fail++;
            $display("FAIL midreset_out: got %h/%b, expected 00000000/0000", result, flags);
        end
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL midreset_nodone: got %0d done pulses, expected 0", dones);
        end
        run_op(32'h40000000, 32'h40000000, r, f, lat, bok, pok);
        n_checks++;
        if (r !== 32'h40800000 || f !== 4'b0000 || lat !== 5) begin
            n_fail++;
            $display("FAIL midreset_fresh: got %h/%b lat %0d, expected 40800000/0000 lat 5",
                     r, f, lat);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        logic [31:0] r;
        r = '0;
        dones = 0;
        @(negedge clk);
        a = 32'h40400000;
        b = 32'h40400000;
        start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                r = result;
            end
            start = (n == 2 || n == 4 || n == 5);
            a = 32'h3F800000;
            b = 32'h3F800000;
        end
        start = 1'b0;
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL ignored_start_count: got %0d done pulses, expected 1", dones);
        end
        n_checks++;
        if (r !== 32'h41100000) begin
            n_fail++;
            $display("FAIL ignored_start_result: got %h, expected 41100000", r);
        end
    endtask

    task automatic test_half();
        logic [15:0] va[3], vb[3], vr[3];
        logic [3:0] vf[3];
        int lat, n;
        va = '{16'h3E00, 16'h3C00, 16'h7800};
        vb = '{16'h4000, 16'h3C00, 16'h7800};
        vr = '{16'h4200, 16'h3C00, 16'h7C00};
        vf = '{4'b0000, 4'b0000, 4'b0101};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_h = va[i];
            b_h = vb[i];
            start_h = 1'b1;
            lat = -1;
            n = 0;
            while (lat < 0 && n < 20) begin
                @(negedge clk);
                n++;
                start_h = 1'b0;
                if (done_h === 1'b1) lat = n - 1;
            end
            n_checks++;
            if (result_h !== vr[i] || flags_h !== vf[i] || lat !== 5) begin
                n_fail++;
                $display("FAIL half[%0d] %h*%h: got %h/%b lat %0d, expected %h/%b lat 5",
                         i, va[i], vb[i], result_h, flags_h, lat, vr[i], vf[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_reset_mid();
        test_back_to_back();
        test_half();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
